// File: rtl/gps_iq_deser.sv
// Deserialises a demodulator's serial IQ accumulator chain into a word FIFO.
// Each epoch pulse triggers a parallel load followed by NWORDS*INTEG_BITS shift cycles.
module gps_iq_deser #(
   parameter int unsigned INTEG_BITS = 20,
   parameter int unsigned NWORDS     = 6,
   parameter int unsigned FIFO_DEPTH = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ms0,
   input  logic                          sout,
   output logic                          shift,
   input  logic                          clr,
   input  logic                          rd,
   output logic [INTEG_BITS-1:0]         dout,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          busy,
   output logic                          frame_rdy,
   output logic                          ovfl,
   output logic                          collide,
   output logic [7:0]                    drop_cnt
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned BW = (INTEG_BITS > 1) ? $clog2(INTEG_BITS) : 1;
   localparam int unsigned WW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   localparam logic [CW-1:0] MaxAdmit = CW'(FIFO_DEPTH - NWORDS);
   localparam logic [BW-1:0] LastBit  = BW'(INTEG_BITS - 1);
   localparam logic [WW-1:0] LastWord = WW'(NWORDS - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

   state_e                 state_q, state_d;
   logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [WW-1:0]          word_cnt_q, word_cnt_d;
   logic [INTEG_BITS-1:0]  shreg_q, shreg_d;
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   ovfl_q, ovfl_d;
   logic                   collide_q, collide_d;
   logic [7:0]             drop_q, drop_d;
   logic [INTEG_BITS-1:0]  mem_q [FIFO_DEPTH];

   logic                   has_room;
   logic                   word_done;
   logic                   last_word;
   logic                   wr_en;
   logic                   pop;
   logic [INTEG_BITS-1:0]  wr_data;

   // Admission reserves room for a whole frame, so mid-frame writes never overflow.
   assign has_room  = (count_q <= MaxAdmit);
   assign word_done = (bit_cnt_q == LastBit);
   assign last_word = (word_cnt_q == LastWord);
   assign wr_data   = {shreg_q[INTEG_BITS-2:0], sout};
   assign wr_en     = shift && word_done && !clr;
   assign pop       = rd && (count_q != '0) && !clr;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:  if (ms0 && has_room) state_d = StLoad;
            StLoad:  state_d = StShift;
            StShift: if (word_done && last_word) state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // FSM outputs
   always_comb begin
      shift     = (state_q == StShift);
      busy      = (state_q != StIdle);
      frame_rdy = (state_q == StShift) && word_done && last_word && !clr;
   end

   // Datapath next state
   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      shreg_d    = shreg_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      ovfl_d     = ovfl_q;
      collide_d  = collide_q;
      drop_d     = drop_q;
      if (clr) begin
         bit_cnt_d  = '0;
         word_cnt_d = '0;
         shreg_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         ovfl_d     = 1'b0;
         collide_d  = 1'b0;
         drop_d     = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(wr_en) - CW'(pop);

         if (state_q == StIdle) begin
            if (ms0) begin
               if (has_room) begin
                  bit_cnt_d  = '0;
                  word_cnt_d = '0;
               end else begin
                  ovfl_d = 1'b1;
                  if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
               end
            end
         end else if (ms0) begin
            collide_d = 1'b1;
         end

         if (state_q == StShift) begin
            shreg_d = wr_data;
            if (word_done) begin
               bit_cnt_d  = '0;
               word_cnt_d = last_word ? '0 : word_cnt_q + WW'(1);
            end else begin
               bit_cnt_d = bit_cnt_q + BW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         shreg_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovfl_q     <= 1'b0;
         collide_q  <= 1'b0;
         drop_q     <= '0;
      end else begin
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         shreg_q    <= shreg_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovfl_q     <= ovfl_d;
         collide_q  <= collide_d;
         drop_q     <= drop_d;
      end
   end

   // Storage needs no reset: contents are only visible through valid pointers.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_data;
   end

   assign dout     = mem_q[rd_ptr_q];
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign ovfl     = ovfl_q;
   assign collide  = collide_q;
   assign drop_cnt = drop_q;

   a_shift_busy : assert property (@(posedge clk) disable iff (!rst_n) shift |-> busy);
   a_count_max  : assert property (@(posedge clk) disable iff (!rst_n)
                                   count_q <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_gps_iq_deser.sv
// Bench for gps_iq_deser: epoch-level model with a serial demodulator stand-in,
// per-cycle output comparison and directed scenarios with literal expectations.
module tb_gps_iq_deser;

   localparam int W     = 20;
   localparam int NW    = 6;
   localparam int DEPTH = 32;
   localparam int NB    = W * NW;
   localparam int CW    = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ms0 = 1'b0;
   logic          sout = 1'b0;
   logic          clr = 1'b0;
   logic          rd = 1'b0;
   logic          shift;
   logic [W-1:0]  dout;
   logic          empty;
   logic [CW-1:0] count;
   logic          busy;
   logic          frame_rdy;
   logic          ovfl;
   logic          collide;
   logic [7:0]    drop_cnt;

   gps_iq_deser #(
      .INTEG_BITS (W),
      .NWORDS     (NW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ms0       (ms0),
      .sout      (sout),
      .shift     (shift),
      .clr       (clr),
      .rd        (rd),
      .dout      (dout),
      .empty     (empty),
      .count     (count),
      .busy      (busy),
      .frame_rdy (frame_rdy),
      .ovfl      (ovfl),
      .collide   (collide),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Model state
   logic [W-1:0]  mq[$];
   bit            act = 1'b0;
   int            ft = 0;
   logic [W-1:0]  fw [NW];
   logic [W-1:0]  nw_words [NW];
   bit            m_ovfl = 1'b0;
   bit            m_coll = 1'b0;
   int            m_drop = 0;
   logic [NB-1:0] ser = '0;
   bit            shift_n = 1'b0;
   bit            shift_prev = 1'b0;
   int            first_shift = -1;
   int            rdy_cyc = -1;

   task automatic chk(input string name, input logic [31:0] actv, input logic [31:0] expv);
      tests++;
      if (actv !== expv) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actv, expv, cyc);
      end
   endtask

   function automatic bit m_busy(input int c);
      return act && (c >= ft + 1) && (c <= ft + 1 + NB);
   endfunction

   function automatic logic [NB-1:0] pack(input logic [W-1:0] w [NW]);
      logic [NB-1:0] v = '0;
      for (int k = 0; k < NW; k++) v = (v << W) | NB'(w[k]);
      return v;
   endfunction

   // Epoch-level model plus serial demodulator: evaluates the inputs of the cycle just ended.
   initial forever begin
      int  c;
      int  sz0;
      bit  bz;
      bit  acc;
      @(posedge clk);
      #1;
      c   = cyc;
      acc = 1'b0;
      if (!rst_n || clr) begin
         mq.delete();
         act    = 1'b0;
         m_ovfl = 1'b0;
         m_coll = 1'b0;
         m_drop = 0;
      end else begin
         sz0 = mq.size();
         bz  = m_busy(c);
         if (rd && sz0 > 0) void'(mq.pop_front());
         if (act && c >= ft + 1 + W && c <= ft + 1 + NB && ((c - ft - 1) % W) == 0)
            mq.push_back(fw[(c - ft - 1) / W - 1]);
         if (ms0) begin
            if (bz) m_coll = 1'b1;
            else if (DEPTH - sz0 >= NW) begin
               act = 1'b1;
               ft  = c;
               fw  = nw_words;
               acc = 1'b1;
            end else begin
               m_ovfl = 1'b1;
               if (m_drop < 255) m_drop++;
            end
         end
      end
      if (acc) ser = pack(nw_words);
      else if (shift_n) ser = ser << 1;
      sout = ser[NB-1];
      cyc++;
   end

   // Per-cycle comparison
   initial forever begin
      @(negedge clk);
      shift_n = shift;
      if (rst_n) begin
         chk("busy", busy, m_busy(cyc));
         chk("shift", shift, act && cyc >= ft + 2 && cyc <= ft + 1 + NB);
         chk("frame_rdy", frame_rdy, act && cyc == ft + 1 + NB);
         chk("count", count, mq.size());
         chk("empty", empty, mq.size() == 0);
         if (mq.size() > 0) chk("dout", dout, mq[0]);
         chk("ovfl", ovfl, m_ovfl);
         chk("collide", collide, m_coll);
         chk("drop_cnt", drop_cnt, m_drop);
         if (shift && !shift_prev) first_shift = cyc;
         if (frame_rdy) rdy_cyc = cyc;
      end
      shift_prev = shift;
   end

   task automatic pulse_ms0(output int t);
      ms0 = 1'b1;
      t   = cyc;
      @(negedge clk);
      ms0 = 1'b0;
   endtask

   task automatic rand_words();
      for (int k = 0; k < NW; k++) nw_words[k] = W'($urandom);
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_shift"}, shift, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_rdy"}, frame_rdy, 0);
      chk({tag, "_empty"}, empty, 1);
      chk({tag, "_count"}, count, 0);
      chk({tag, "_ovfl"}, ovfl, 0);
      chk({tag, "_collide"}, collide, 0);
      chk({tag, "_drop"}, drop_cnt, 0);
   endtask

   initial begin
      int t;
      int dummy;
      for (int k = 0; k < NW; k++) nw_words[k] = W'(k + 1);
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic frame: words 1..6
      pulse_ms0(t);
      wait_to(t + 125);
      chk("first_shift", first_shift, t + 2);
      chk("rdy_cycle", rdy_cyc, t + 121);
      chk("basic_count", count, 6);
      for (int k = 0; k < NW; k++) begin
         chk("basic_word", dout, k + 1);
         rd = 1'b1;
         @(negedge clk);
         rd = 1'b0;
      end
      chk("basic_empty", empty, 1);

      // Overflow: fill to 27 words, then drop epochs
      for (int f = 0; f < 5; f++) begin
         rand_words();
         pulse_ms0(t);
         wait_to(t + 123);
      end
      rd = 1'b1;
      repeat (3) @(negedge clk);
      rd = 1'b0;
      chk("fill_count", count, 27);
      pulse_ms0(t);
      chk("ovfl_set", ovfl, 1);
      chk("drop_one", drop_cnt, 1);
      chk("ovfl_count", count, 27);
      chk("ovfl_noshift", shift, 0);
      @(negedge clk);
      chk("ovfl_noshift2", shift, 0);
      for (int i = 0; i < 255; i++) begin
         pulse_ms0(dummy);
         @(negedge clk);
      end
      chk("drop_sat", drop_cnt, 255);
      chk("sat_count", count, 27);

      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_empty", empty, 1);
      chk("clr_ovfl", ovfl, 0);
      chk("clr_drop", drop_cnt, 0);

      // Collision at t+50
      rand_words();
      pulse_ms0(t);
      wait_to(t + 50);
      pulse_ms0(dummy);
      chk("collide_set", collide, 1);
      wait_to(t + 123);
      chk("collide_count", count, 6);

      // Pops coincident with every write: count stays at 6
      rand_words();
      pulse_ms0(t);
      for (int k = 0; k < NW; k++) begin
         wait_to(t + 21 + 20 * k);
         rd = 1'b1;
         @(negedge clk);
         rd = 1'b0;
         chk("rdwr_count", count, 6);
      end
      wait_to(t + 123);
      rd = 1'b1;
      repeat (8) @(negedge clk);
      rd = 1'b0;
      chk("rd_empty_count", count, 0);
      chk("rd_empty_flag", empty, 1);

      // clr mid-frame at t+60
      rand_words();
      pulse_ms0(t);
      wait_to(t + 60);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_mid_shift", shift, 0);
      chk("clr_mid_busy", busy, 0);
      chk("clr_mid_empty", empty, 1);
      chk("clr_mid_collide", collide, 0);
      ms0 = 1'b1;
      clr = 1'b1;
      @(negedge clk);
      ms0 = 1'b0;
      clr = 1'b0;
      chk("clr_vs_ms0", busy, 0);
      @(negedge clk);
      chk("clr_vs_ms0_shift", shift, 0);

      // Asynchronous reset mid-frame, then a fresh frame
      rand_words();
      pulse_ms0(t);
      wait_to(t + 20);
      pulse_ms0(dummy);
      wait_to(t + 40);
      #3 rst_n = 1'b0;
      #1 check_reset_vals("async");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rand_words();
      pulse_ms0(t);
      wait_to(t + 123);
      chk("fresh_count", count, 6);
      chk("fresh_collide", collide, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
